// File: rtl/reg_file_8x16_pkg.sv
// Shared constants and types for the 8x16 register file.
package reg_file_8x16_pkg;

  localparam int RF_NUM_REGS = 8;
  localparam int RF_SEL_W    = 3;
  localparam int RF_DATA_W   = 16;

  typedef logic [RF_DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/reg_file_8x16_onehot_check.sv
// Classifies an 8-bit enable vector as exactly-one-hot or multi-hot.
// Usable anywhere a decoder output needs to be sanity-checked.
module onehot_check (
  input  logic [7:0] vec,
  output logic       is_one,
  output logic       is_multi
);

  logic [7:0] low_cleared;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    low_cleared = vec & (vec - 8'd1);
    is_multi    = (low_cleared != 8'd0);
    is_one      = (vec != 8'd0) && !is_multi;
  end

endmodule

// File: rtl/reg_file_8x16.sv
// Eight-entry register file fed by a one-hot write enable, with two
// registered read ports, write-first bypass and malformed-enable detection.
//
// Output qualifier: rd_valid is a one-cycle pulse per accepted read
// request. It is high in the cycle after rd_en was sampled high, and
// rd_data_a/rd_data_b carry the result in that same cycle. There is no
// back-pressure; a read issued every cycle keeps rd_valid high throughout.
// When rd_valid is low the data outputs hold their last values.
module reg_file_8x16
  import reg_file_8x16_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic [7:0]          we_onehot,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [RF_SEL_W-1:0] rd_sel_a,
  input  logic [RF_SEL_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_valid,
  output logic                wr_err,
  output logic                err_sticky
);

  logic [DATA_W-1:0] regs [RF_NUM_REGS];

  logic              we_is_one;
  logic              we_is_multi;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  onehot_check u_onehot_check (
    .vec      (we_onehot),
    .is_one   (we_is_one),
    .is_multi (we_is_multi)
  );

  // Read-port muxes: clr forces zero, a same-cycle legal write is bypassed,
  // otherwise the stored value is returned (also for rejected writes).
  always_comb begin
    hit_a  = we_is_one && we_onehot[rd_sel_a];
    hit_b  = we_is_one && we_onehot[rd_sel_b];
    next_a = regs[rd_sel_a];
    next_b = regs[rd_sel_b];
    if (clr) begin
      next_a = '0;
      next_b = '0;
    end else begin
      if (hit_a) next_a = wr_data;
      if (hit_b) next_b = wr_data;
    end
  end

  // Storage: clr beats any write; only a strictly one-hot enable writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RF_NUM_REGS; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RF_NUM_REGS; i++) regs[i] <= '0;
    end else if (we_is_one) begin
      for (int i = 0; i < RF_NUM_REGS; i++) begin
        if (we_onehot[i]) regs[i] <= wr_data;
      end
    end
  end

  // Registered read outputs; data holds when no read is requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= next_a;
        rd_data_b <= next_b;
      end
    end
  end

  // Error flops: the pulse reports every malformed cycle, the sticky bit
  // is suppressed when clr arrives in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wr_err <= we_is_multi;
      if (clr) err_sticky <= 1'b0;
      else     err_sticky <= err_sticky | we_is_multi;
    end
  end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed testbench for reg_file_8x16.
module tb_reg_file_8x16;
  import reg_file_8x16_pkg::*;

  logic                clk;
  logic                reset;
  logic                clr;
  logic [7:0]          we_onehot;
  rf_word_t            wr_data;
  logic                rd_en;
  logic [RF_SEL_W-1:0] rd_sel_a;
  logic [RF_SEL_W-1:0] rd_sel_b;
  rf_word_t            rd_data_a;
  rf_word_t            rd_data_b;
  logic                rd_valid;
  logic                wr_err;
  logic                err_sticky;

  int pass_cnt  = 0;
  int total_cnt = 0;

  reg_file_8x16 #(.DATA_W(RF_DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .we_onehot  (we_onehot),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_sel_a   (rd_sel_a),
    .rd_sel_b   (rd_sel_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .rd_valid   (rd_valid),
    .wr_err     (wr_err),
    .err_sticky (err_sticky)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr       = 1'b0;
    we_onehot = 8'h00;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_sel_a  = '0;
    rd_sel_b  = '0;
  endtask

  task automatic do_write(input int idx, input rf_word_t data);
    idle();
    we_onehot      = 8'h00;
    we_onehot[idx] = 1'b1;
    wr_data        = data;
    tick();
  endtask

  task automatic do_read(input int sa, input int sb);
    idle();
    rd_en    = 1'b1;
    rd_sel_a = RF_SEL_W'(sa);
    rd_sel_b = RF_SEL_W'(sb);
    tick();
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // Reset state
    #2 reset = 1'b1;
    #2;
    check("reset_rd_a",     rd_data_a, 16'h0000);
    check("reset_rd_b",     rd_data_b, 16'h0000);
    check("reset_valid",    16'(rd_valid), 16'h0000);
    check("reset_wr_err",   16'(wr_err), 16'h0000);
    check("reset_sticky",   16'(err_sticky), 16'h0000);
    tick();
    tick();
    reset = 1'b0;

    // Reset then read
    do_read(3, 7);
    check("rst_read_a",     rd_data_a, 16'h0000);
    check("rst_read_b",     rd_data_b, 16'h0000);
    check("rst_read_valid", 16'(rd_valid), 16'h0001);

    // Write / readback
    do_write(5, 16'hA5A5);
    check("no_read_valid",  16'(rd_valid), 16'h0000);
    do_read(5, 0);
    check("wr5_read_a",     rd_data_a, 16'hA5A5);
    check("wr5_read_b0",    rd_data_b, 16'h0000);
    for (int i = 0; i < RF_NUM_REGS; i++) begin
      if (i != 5) begin
        do_read(i, i);
        check($sformatf("other_reg%0d", i), rd_data_a, 16'h0000);
        check("back_to_back_valid", 16'(rd_valid), 16'h0001);
      end
    end

    // Bypass: write and read the same register in one cycle
    idle();
    we_onehot = 8'b0000_0010;
    wr_data   = 16'h1234;
    rd_en     = 1'b1;
    rd_sel_a  = 3'd1;
    rd_sel_b  = 3'd1;
    tick();
    check("bypass_a",       rd_data_a, 16'h1234);
    check("bypass_b",       rd_data_b, 16'h1234);
    do_read(1, 5);
    check("stored_reg1",    rd_data_a, 16'h1234);
    check("stored_reg5",    rd_data_b, 16'hA5A5);

    // Malformed enable, read in the same cycle sees stored values
    do_write(2, 16'h0002);
    do_write(3, 16'h0003);
    check("sticky_clean",   16'(err_sticky), 16'h0000);
    idle();
    we_onehot = 8'b0000_1100;
    wr_data   = 16'hFFFF;
    rd_en     = 1'b1;
    rd_sel_a  = 3'd2;
    rd_sel_b  = 3'd3;
    tick();
    check("bad_wr_err",     16'(wr_err), 16'h0001);
    check("bad_sticky",     16'(err_sticky), 16'h0001);
    check("bad_same_a",     rd_data_a, 16'h0002);
    check("bad_same_b",     rd_data_b, 16'h0003);
    do_read(2, 3);
    check("err_pulse_end",  16'(wr_err), 16'h0000);
    check("sticky_holds",   16'(err_sticky), 16'h0001);
    check("reg2_intact",    rd_data_a, 16'h0002);
    check("reg3_intact",    rd_data_b, 16'h0003);

    // Clear precedence over a valid write
    idle();
    clr       = 1'b1;
    we_onehot = 8'b1000_0000;
    wr_data   = 16'hBEEF;
    rd_en     = 1'b1;
    rd_sel_a  = 3'd7;
    rd_sel_b  = 3'd5;
    tick();
    check("clr_sticky",     16'(err_sticky), 16'h0000);
    check("clr_read_a",     rd_data_a, 16'h0000);
    check("clr_read_b",     rd_data_b, 16'h0000);
    check("clr_valid",      16'(rd_valid), 16'h0001);
    do_read(7, 2);
    check("reg7_cleared",   rd_data_a, 16'h0000);
    check("reg2_cleared",   rd_data_b, 16'h0000);

    // Malformed enable during clr: pulse yes, sticky no
    idle();
    clr       = 1'b1;
    we_onehot = 8'b0000_0011;
    tick();
    check("clr_bad_wr_err", 16'(wr_err), 16'h0001);
    check("clr_bad_sticky", 16'(err_sticky), 16'h0000);
    idle();
    tick();
    check("clr_bad_after",  16'(err_sticky), 16'h0000);
    check("clr_bad_pulse",  16'(wr_err), 16'h0000);

    // Async reset mid-read
    do_write(4, 16'h7777);
    do_read(4, 4);
    check("reg4_read",      rd_data_a, 16'h7777);
    #2 reset = 1'b1;
    #1;
    check("async_rd_a",     rd_data_a, 16'h0000);
    check("async_rd_b",     rd_data_b, 16'h0000);
    check("async_valid",    16'(rd_valid), 16'h0000);
    #1 reset = 1'b0;
    tick();
    check("post_rst_reg4",  rd_data_a, 16'h0000);
    check("post_rst_valid", 16'(rd_valid), 16'h0001);

    // Final report
    idle();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
